// File: rtl/scanner_receiver.sv
// Scanner link receiver: requests a frame, deserialises the synchronised serial clock/data MSB-first,
// and buffers the words in a FIFO that is drained over a valid/ready byte interface.
module scanner_receiver #(
    parameter int WORD_W      = 8,
    parameter int FRAME_WORDS = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT     = 64,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              serialClkIn_i,
    input  logic              serialDataIn_i,
    output logic              readyForTransferOut_o,
    output logic [WORD_W-1:0] byteOut_o,
    output logic              byteValid_o,
    input  logic              byteReady_i,
    output logic              frameDone_o,
    output logic              frameError_o,
    output logic [CW-1:0]     fifoCount_o
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(WORD_W + 1);
    localparam int WCW = $clog2(FRAME_WORDS + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RECV = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0]  REQ_MAX   = CW'(FIFO_DEPTH - FRAME_WORDS);
    localparam logic [BW-1:0]  LAST_BIT  = BW'(WORD_W - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT - 1);

    logic              sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic              sdat_s1_q, sdat_s2_q;
    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]    word_cnt_q, word_cnt_d;
    logic [TW-1:0]     idle_cnt_q, idle_cnt_d;
    logic              push_q, push_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              edge_w, pop_w;

    assign edge_w = sclk_s2_q & ~sclk_prev_q;
    assign pop_w  = (count_q != '0) && byteReady_i;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        idle_cnt_d = idle_cnt_q;
        push_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i && (count_q <= REQ_MAX)) state_d = S_REQ;
            end
            S_REQ: begin
                if (edge_w) begin
                    shift_d    = {shift_q[WORD_W-2:0], sdat_s2_q};
                    bit_cnt_d  = BW'(1);
                    idle_cnt_d = '0;
                    state_d    = S_RECV;
                end else if (!enable_i) begin
                    state_d = S_IDLE;
                end
            end
            S_RECV: begin
                if (edge_w) begin
                    shift_d    = {shift_q[WORD_W-2:0], sdat_s2_q};
                    idle_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        push_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else if (idle_cnt_q == TO_LAST && !push_q) begin
                    // Abort: the partial word is dropped, completed words stay queued.
                    err_d      = 1'b1;
                    shift_d    = '0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
                end
                if (push_q) begin
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        idle_cnt_d = '0;
                        state_d    = S_DONE;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            sdat_s1_q   <= 1'b0;
            sdat_s2_q   <= 1'b0;
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            push_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_s1_q   <= serialClkIn_i;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            sdat_s1_q   <= serialDataIn_i;
            sdat_s2_q   <= sdat_s1_q;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            push_q      <= push_d;
            err_q       <= err_d;
        end
    end

    // The completed word sits in shift_q for the cycle after its last bit; no edge can land there.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_q) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_w) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + {{(CW-1){1'b0}}, push_q} - {{(CW-1){1'b0}}, pop_w};
        end
    end

    assign readyForTransferOut_o = (state_q == S_REQ) || (state_q == S_RECV);
    assign frameDone_o           = (state_q == S_DONE);
    assign frameError_o          = err_q;
    assign byteOut_o             = mem_q[rd_ptr_q];
    assign byteValid_o           = (count_q != '0);
    assign fifoCount_o           = count_q;
endmodule

// File: tb/tb_scanner_receiver.sv
// Directed bench for scanner_receiver: a serial-link driver, and a scoreboard queue popped on every accepted byte.
module tb_scanner_receiver;
    logic       clk = 1'b0;
    logic       rst_n, enable, sclk, sdat, bready;
    logic       rdy, bvalid, fdone, ferr;
    logic [7:0] bout;
    logic [3:0] fcount;

    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         exp_done = 0;
    logic [7:0] exp_q [$];
    logic [7:0] tbl [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    scanner_receiver dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .enable_i              (enable),
        .serialClkIn_i         (sclk),
        .serialDataIn_i        (sdat),
        .readyForTransferOut_o (rdy),
        .byteOut_o             (bout),
        .byteValid_o           (bvalid),
        .byteReady_i           (bready),
        .frameDone_o           (fdone),
        .frameError_o          (ferr),
        .fifoCount_o           (fcount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer side of the scoreboard: every accepted byte must match the oldest expected one.
    always @(negedge clk) begin
        if (bvalid && bready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL pop_unexpected: observed %0h expected none", bout);
            end else begin
                check("pop_byte", bout, exp_q.pop_front());
            end
        end
        if (fdone) begin
            done_cnt++;
            check("rdy_low_in_done", rdy, 0);
        end
        if (ferr) err_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sclk = 1'b0;
            sdat = w[i];
            cyc(4);
            sclk = 1'b1;
            cyc(4);
        end
    endtask

    task automatic wait_rdy(input string tag);
        int k;
        for (k = 0; k < 200 && !rdy; k++) cyc(1);
        check(tag, rdy, 1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 100 && done_cnt < exp_done; k++) cyc(1);
        check(tag, done_cnt, exp_done);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input string tag);
        wait_rdy({tag, "_req"});
        exp_q.push_back(a);
        exp_q.push_back(b);
        send_bits(a, 8);
        send_bits(b, 8);
        exp_done++;
        wait_done({tag, "_done"});
    endtask

    task automatic drain(input string tag);
        int k;
        bready = 1'b1;
        for (k = 0; k < 50 && fcount != 0; k++) cyc(1);
        bready = 1'b0;
        cyc(1);
        check({tag, "_empty"}, fcount, 0);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int  cnt;
        logic seen;
        rst_n = 1'b0; enable = 1'b0; sclk = 1'b0; sdat = 1'b0; bready = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        check("rst_rdy", rdy, 0);
        check("rst_valid", bvalid, 0);
        check("rst_done", fdone, 0);
        check("rst_err", ferr, 0);
        check("rst_count", fcount, 0);
        check("rst_byte", bout, 0);

        // 1: request within two cycles of enable
        enable = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            cyc(1);
            seen = rdy;
        end
        check("req_within_2", seen, 1);

        // 2: basic frame
        send_frame(8'hA5, 8'h3C, "t2");
        check("t2_count", fcount, 2);
        drain("t2");

        // 3: fill the FIFO, then confirm no request until two slots free up
        for (int f = 0; f < 4; f++) send_frame(tbl[2*f], tbl[2*f+1], "t3");
        check("t3_full", fcount, 8);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (rdy) seen = 1'b1;
        end
        check("t3_no_req_full", seen, 0);
        bready = 1'b1;
        cyc(2);
        bready = 1'b0;
        check("t3_after_pop2", fcount, 6);
        wait_rdy("t3_rereq");

        // 4: serial clock stops after 5 bits
        send_bits(8'hB7, 4);
        sclk = 1'b0; sdat = 1'b0;
        cyc(4);
        sclk = 1'b1;
        cnt = 0;
        while (!ferr && cnt < 100) begin
            cyc(1);
            cnt++;
        end
        check("t4_timeout_window", (cnt >= 64 && cnt <= 68), 1);
        cyc(1);
        check("t4_err_1cycle", ferr, 0);
        check("t4_err_count", err_cnt, 1);
        check("t4_count_kept", fcount, 6);
        check("t4_no_done", done_cnt, exp_done);
        wait_rdy("t4_rereq");

        // 5: simultaneous push/pop at count 3, order kept across pointer wrap
        bready = 1'b1;
        cyc(3);
        bready = 1'b0;
        check("t5_count3", fcount, 3);
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'h7D);
        send_bits(8'hE1, 7);
        sclk = 1'b0; sdat = 1'b1;
        cyc(4);
        sclk = 1'b1;
        cyc(3);
        check("t5_before_pushpop", fcount, 3);
        bready = 1'b1;
        cyc(1);
        bready = 1'b0;
        check("t5_pushpop_count", fcount, 3);
        cyc(3);
        send_bits(8'h7D, 8);
        exp_done++;
        wait_done("t5_done");
        check("t5_count4", fcount, 4);
        drain("t5");

        // 6: reset mid-word with data queued
        send_frame(8'h11, 8'h22, "t6a");
        wait_rdy("t6_req");
        send_bits(8'h99, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rdy", rdy, 0);
        check("t6_rst_valid", bvalid, 0);
        check("t6_rst_count", fcount, 0);
        check("t6_rst_byte", bout, 0);
        check("t6_rst_done", fdone, 0);
        check("t6_rst_err", ferr, 0);
        exp_q.delete();
        sclk = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        send_frame(8'h5A, 8'hC3, "t6b");
        check("t6_count", fcount, 2);
        drain("t6");
        check("total_errors", err_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
